// File: rtl/md_pad6.sv
// md_pad6: Sega 6-button control pad emulation on one 7-bit controller port.
// Counts host TH falling edges to select the 3-button, zero-nibble, extended
// (MODE/X/Y/Z) or all-ones data set. A TH-idle timeout restarts the sequence.
module md_pad6 #(
  parameter int unsigned TIMEOUT    = 80000,
  parameter bit          SIX_BUTTON = 1'b1
) (
  input  logic        MCLK,
  input  logic        ext_reset_n,
  input  logic        connected,
  input  logic [11:0] btn,
  input  logic [6:0]  PA_o,
  input  logic [6:0]  PA_d,
  output logic [6:0]  PA_i,
  output logic [2:0]  phase
);

  localparam int unsigned TmrW = 17;
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT);

  // Button bit positions in btn (pressed = 1)
  localparam int unsigned BtnUp    = 0;
  localparam int unsigned BtnDown  = 1;
  localparam int unsigned BtnLeft  = 2;
  localparam int unsigned BtnRight = 3;
  localparam int unsigned BtnA     = 4;
  localparam int unsigned BtnB     = 5;
  localparam int unsigned BtnC     = 6;
  localparam int unsigned BtnStart = 7;
  localparam int unsigned BtnX     = 8;
  localparam int unsigned BtnY     = 9;
  localparam int unsigned BtnZ     = 10;
  localparam int unsigned BtnMode  = 11;

  localparam logic [2:0] CntMax = 3'd4;

  logic            th;
  logic            th_q, th_d;
  logic            fall, rise, th_edge;
  logic [2:0]      cnt_q, cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            tmr_expire;
  logic [11:0]     p;
  logic [6:0]      pad;
  logic [6:0]      pa_i_q, pa_i_d;

  // TH level seen on the wire: pulled up whenever the host is not driving it
  always_comb begin
    th   = PA_d[6] ? 1'b1 : PA_o[6];
    th_d = th;
  end

  // Edge detection against last cycle's TH level
  always_comb begin
    fall    = th_q & ~th;
    rise    = ~th_q & th;
    th_edge = fall | rise;
  end

  // Idle timer: any TH edge restarts it, otherwise it climbs and parks at TIMEOUT
  always_comb begin
    tmr_d = tmr_q;
    if (th_edge) begin
      tmr_d = '0;
    end else if (tmr_q < TmrMax) begin
      tmr_d = tmr_q + {{(TmrW-1){1'b0}}, 1'b1};
    end
    // Clearing on the cycle the timer lands on TIMEOUT; an edge always wins
    tmr_expire = ~th_edge & (tmr_d == TmrMax);
  end

  // Falling-edge counter, saturating at 4, cleared by the idle timeout
  always_comb begin
    cnt_d = cnt_q;
    if (!SIX_BUTTON) begin
      cnt_d = 3'd0;
    end else if (fall) begin
      if (cnt_q < CntMax) begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (rise) begin
      cnt_d = cnt_q;
    end else if (tmr_expire) begin
      cnt_d = 3'd0;
    end
  end

  // Pad data nibble selected by TH and the post-update edge count
  always_comb begin
    p = ~btn;
    if (th) begin
      if (cnt_d == 3'd3) begin
        pad = {1'b1, p[BtnC], p[BtnB], p[BtnMode], p[BtnX], p[BtnY], p[BtnZ]};
      end else begin
        pad = {1'b1, p[BtnC], p[BtnB], p[BtnRight], p[BtnLeft], p[BtnDown], p[BtnUp]};
      end
    end else begin
      unique case (cnt_d)
        3'd3:    pad = {1'b0, p[BtnStart], p[BtnA], 4'b0000};
        3'd4:    pad = {1'b0, p[BtnStart], p[BtnA], 4'b1111};
        default: pad = {1'b0, p[BtnStart], p[BtnA], 2'b00, p[BtnDown], p[BtnUp]};
      endcase
    end
    // Unplugged pad: everything reads pulled-up; counter/timer keep running
    if (!connected) begin
      pad = 7'h7F;
    end
  end

  // Merge pad data with host-driven pins; bit 6 always reflects TH
  always_comb begin
    pa_i_d = 7'h00;
    for (int i = 0; i < 6; i++) begin
      pa_i_d[i] = PA_d[i] ? pad[i] : PA_o[i];
    end
    pa_i_d[6] = th;
  end

  // State registers; reset leaves the timer expired so the first fall is edge 1
  always_ff @(posedge MCLK or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      th_q   <= 1'b1;
      cnt_q  <= 3'd0;
      tmr_q  <= TmrMax;
      pa_i_q <= 7'h7F;
    end else begin
      th_q   <= th_d;
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      pa_i_q <= pa_i_d;
    end
  end

  // Registered outputs
  always_comb begin
    PA_i  = pa_i_q;
    phase = cnt_q;
  end

endmodule

// File: tb/tb_md_pad6.sv
// tb_md_pad6: directed bench for md_pad6 (6-button and 3-button instances).
module tb_md_pad6;

  localparam int unsigned Tmo = 600;

  // btn bit masks
  localparam logic [11:0] BAStart = 12'h090;  // A | START
  localparam logic [11:0] BXMode  = 12'h900;  // X | MODE
  localparam logic [11:0] BMixed  = 12'h909;  // MODE | X | RIGHT | UP

  logic        clk;
  logic        rst_n;
  logic        conn;
  logic [11:0] btn;
  logic [6:0]  pa_o;
  logic [6:0]  pa_d;
  logic [6:0]  pa_i6, pa_i3;
  logic [2:0]  ph6, ph3;

  int n_total = 0;
  int n_bad   = 0;

  md_pad6 #(
    .TIMEOUT    (Tmo),
    .SIX_BUTTON (1'b1)
  ) u_dut6 (
    .MCLK        (clk),
    .ext_reset_n (rst_n),
    .connected   (conn),
    .btn         (btn),
    .PA_o        (pa_o),
    .PA_d        (pa_d),
    .PA_i        (pa_i6),
    .phase       (ph6)
  );

  md_pad6 #(
    .TIMEOUT    (Tmo),
    .SIX_BUTTON (1'b0)
  ) u_dut3 (
    .MCLK        (clk),
    .ext_reset_n (rst_n),
    .connected   (conn),
    .btn         (btn),
    .PA_o        (pa_o),
    .PA_d        (pa_d),
    .PA_i        (pa_i3),
    .phase       (ph3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n posedges; returns at a negedge so outputs are stable
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_th(input logic v);
    pa_o[6] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    conn  = 1'b1;
    btn   = 12'h000;
    pa_o  = 7'h00;
    pa_d  = 7'h7F;
    #23;
    check_val("rst_pa_i", {25'd0, pa_i6}, 32'h7F);
    check_val("rst_phase", {29'd0, ph6}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check_val("idle_pa_i", {25'd0, pa_i6}, 32'h7F);
    check_val("idle_phase", {29'd0, ph6}, 32'd0);

    // Fall 1 with A+START: {0,pS=0,pA=0,0,0,pD=1,pU=1}
    btn  = BAStart;
    pa_d = 7'h3F;
    set_th(1'b0);
    tick(1);
    check_val("fall1_pa_i", {25'd0, pa_i6}, 32'h03);
    check_val("fall1_phase", {29'd0, ph6}, 32'd1);
    tick(199);
    set_th(1'b1);
    tick(1);
    check_val("rise1_pa_i", {25'd0, pa_i6}, 32'h7F);
    btn = BXMode;
    tick(199);
    set_th(1'b0);
    tick(1);
    // cnt 2, th 0: {0,1,1,0,0,1,1}
    check_val("fall2_pa_i", {25'd0, pa_i6}, 32'h33);
    check_val("fall2_phase", {29'd0, ph6}, 32'd2);
    tick(199);
    set_th(1'b1);
    tick(199);
    set_th(1'b0);
    tick(1);
    // cnt 3, th 0: {0,1,1,0000}
    check_val("fall3_pa_i", {25'd0, pa_i6}, 32'h30);
    check_val("fall3_phase", {29'd0, ph6}, 32'd3);
    tick(199);
    set_th(1'b1);
    tick(1);
    // cnt 3, th 1: {1,pC=1,pB=1,pM=0,pX=0,pY=1,pZ=1}
    check_val("rise3_pa_i", {25'd0, pa_i6}, 32'h73);
    check_val("rise3_phase", {29'd0, ph6}, 32'd3);
    tick(199);
    set_th(1'b0);
    tick(1);
    check_val("fall4_pa_i", {25'd0, pa_i6}, 32'h3F);
    check_val("fall4_phase", {29'd0, ph6}, 32'd4);
    tick(199);
    set_th(1'b1);
    tick(1);
    check_val("rise4_pa_i", {25'd0, pa_i6}, 32'h7F);
    // Timeout boundary: still 4 one cycle before, 0 exactly at TIMEOUT
    tick(Tmo - 1);
    check_val("tmo_before", {29'd0, ph6}, 32'd4);
    tick(1);
    check_val("tmo_at", {29'd0, ph6}, 32'd0);
    set_th(1'b0);
    tick(1);
    check_val("tmo_fall_phase", {29'd0, ph6}, 32'd1);
    check_val("tmo_fall_pa_i", {25'd0, pa_i6}, 32'h33);

    // Saturation: four more falls leave cnt at 4
    for (int k = 0; k < 4; k++) begin
      tick(20);
      set_th(1'b1);
      tick(20);
      set_th(1'b0);
    end
    tick(1);
    check_val("sat_phase", {29'd0, ph6}, 32'd4);
    check_val("sat_pa_i", {25'd0, pa_i6}, 32'h3F);

    // Asynchronous reset mid-sequence
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_pa_i", {25'd0, pa_i6}, 32'h7F);
    check_val("mid_rst_phase", {29'd0, ph6}, 32'd0);
    set_th(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check_val("post_rst_phase", {29'd0, ph6}, 32'd0);
    set_th(1'b0);
    tick(1);
    check_val("post_rst_fall", {29'd0, ph6}, 32'd1);

    // 3-button instance: count ignored, TH=1 always CBRLDU
    btn = BMixed;
    tick(10);
    set_th(1'b1);
    tick(10);
    for (int k = 0; k < 8; k++) begin
      set_th(1'b0);
      tick(1);
      check_val($sformatf("b3_fall%0d_phase", k), {29'd0, ph3}, 32'd0);
      // {0,pS=1,pA=1,0,0,pD=1,pU=0}
      check_val($sformatf("b3_fall%0d_pa_i", k), {25'd0, pa_i3}, 32'h32);
      tick(9);
      set_th(1'b1);
      tick(1);
      // {1,pC=1,pB=1,pR=0,pL=1,pD=1,pU=0}
      check_val($sformatf("b3_rise%0d_pa_i", k), {25'd0, pa_i3}, 32'h76);
      tick(9);
    end

    // Host-driven pin 0 echoes PA_o
    btn  = 12'h000;
    pa_d = 7'h3E;
    pa_o = 7'h00;
    tick(1);
    check_val("echo_th0", {31'd0, pa_i6[0]}, 32'd0);
    pa_o = 7'h40;
    tick(1);
    check_val("echo_th1", {31'd0, pa_i6[0]}, 32'd0);
    conn = 1'b0;
    tick(1);
    check_val("disc_th1", {25'd0, pa_i6}, 32'h7E);
    pa_o = 7'h00;
    tick(1);
    check_val("disc_th0", {25'd0, pa_i6}, 32'h3E);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
